system_reset_sequencer: RTL
===========================

# system_reset_sequencer

Downstream consumer of the PLL wrapper's `resetrequest`. Holds every clock-domain reset asserted while the PLL is unlocked, a software reset is requested, or power-on reset is active. Once the cause clears, it releases the per-domain resets in a fixed staggered order. An Avalon-MM slave exposes reset cause, sequence state and a software reset trigger.

## Interface
Parameters:
- `NUM_OUTS`, 3: number of sequenced reset outputs (1..8)
- `HOLD_CYCLES`, 16: minimum quiet cycles before the first release (≥2)
- `STAGE_GAP`, 8: cycles between consecutive releases (≥1)
- `CNT_W`, 8: counter width; must hold max(HOLD_CYCLES, STAGE_GAP)

Ports:
- `clk` in 1: single clock; all logic in this domain
- `reset` in 1: asynchronous, active-high
- `pll_resetrequest` in 1: asynchronous level from the PLL wrapper; high = not ready
- `rst_out` out NUM_OUTS: active-high domain resets; bit 0 is released first
- `seq_done` out 1: high when all `rst_out` are deasserted
- `address` in 2: Avalon word address
- `chipselect` in 1: Avalon select
- `read` in 1: Avalon read strobe
- `write` in 1: Avalon write strobe
- `writedata` in 16: Avalon write data
- `readdata` out 16: Avalon read data

## Operation
- Trigger = synchronized `pll_resetrequest` OR sw_req pulse.
- States: ASSERT, RELEASE, RUN.
- **ASSERT**
  - All `rst_out`=1 and `seq_done`=0.
  - Counter clears on any trigger cycle and increments otherwise.
  - When the counter reaches HOLD_CYCLES−1, the next edge goes to RELEASE, clears `rst_out[0]` and zeroes the counter.
- **RELEASE**
  - Index k starts at 1.
  - Each time the counter reaches STAGE_GAP−1, clear `rst_out[k]`, increment k and zero the counter.
  - The edge that clears the last bit moves to RUN and sets `seq_done`.
  - With NUM_OUTS=1, transition directly to RUN on the ASSERT exit edge.
- **RUN**: hold until a trigger occurs.
- A trigger in RELEASE or RUN forces ASSERT. All `rst_out` go to 1 and the counter goes to 0 on the next edge.
- Register map:
  - addr 0 (RO status):
    - bit0 `seq_done`
    - bits2:1 state
    - bit4 cause_pll
    - bit5 cause_sw
    - bit6 cause_por
    - bits 8+NUM_OUTS−1:8 `rst_out`
    - remaining bits 0
  - addr 1 (WO control):
    - bit0=1 issues a one-cycle sw_req.
    - bit1=1 clears all cause flags.
    - Reads return 0.
  - addr 2–3: reads return 0; writes are ignored.
- A write takes effect only when `write` and `chipselect` are both high.
- Cause flags are sticky. cause_pll sets on any synchronized trigger from `pll_resetrequest`, and cause_sw sets on sw_req. A set event in the same cycle as a clear wins.
- `rst_out` never drives the sequencer itself, so a software reset never resets this block's registers.

## Timing
- Reset values:
  - `rst_out` all 1
  - `seq_done` 0
  - state ASSERT
  - counter 0
  - cause_por 1, other causes 0
  - synchronizer flops 1
- `pll_resetrequest` passes through a 2-flop synchronizer: 2-cycle latency into the trigger.
- sw_req asserts on the edge after the accepted write, giving a 1-cycle trigger latency.
- `readdata` is a combinational mux of registered values: zero-latency, valid while `address` is stable.
- Release schedule, with the last trigger seen at edge T:
  - `rst_out[0]` falls at T+HOLD_CYCLES.
  - `rst_out[k]` falls at T+HOLD_CYCLES+k·STAGE_GAP.
  - `seq_done` rises with the last bit.
- Glitch-free outputs: `rst_out` and `seq_done` are driven directly from flops.
- Assertion of `reset` mid-sequence asynchronously returns all outputs to their reset values immediately.

## Structure
- Package `system_reset_pkg`:
  - state encoding (ASSERT=0, RELEASE=1, RUN=2)
  - register addresses (STATUS=0, CONTROL=1)
  - status bit positions
  - control bit positions
- Sub-module `reset_sync_2ff`: 2-flop level synchronizer with asynchronous preset to 1 on `reset`; instantiated once for `pll_resetrequest`.

## Test plan
Defaults: NUM_OUTS=3, HOLD=16, GAP=8.
- **Power-on release**: deassert `reset` with `pll_resetrequest`=0. Required: `rst_out[0]` falls 18 cycles after the first edge, `rst_out[1]` at 26, `rst_out[2]` and `seq_done` at 34. Status reads 0x0045 (cause_por, state RUN, done).
- **PLL relock**: hold `pll_resetrequest`=1 for 100 cycles, then drop it. Required: all `rst_out`=1 by 3 cycles after the rise; release at +18/+26/+34 after the fall; cause_pll=1.
- **Software reset**: write 0x0001 to addr 1 while in RUN. Required: `rst_out`=0b111 two edges after the write; release 17/25/33 cycles after sw_req; cause_sw=1.
- **Mid-release retrigger**: pulse `pll_resetrequest` after `rst_out[0]` has cleared. Required: `rst_out[0]` reasserts, and the full schedule restarts from the new quiet point.
- **Cause clear race**: write 0x0002 to addr 1 in the same cycle a sw_req from the previous cycle sets cause_sw. Required: cause_sw reads 1, while cause_por and cause_pll read 0.
- **Async reset mid-RELEASE**: assert `reset` with no clock edge. Required: `rst_out`=0b111, `seq_done`=0 and `readdata` at addr 0 shows cause_por immediately.

Source files
------------

// File: rtl/system_reset_pkg.sv
// Shared encodings for the system reset sequencer: FSM states, register map and bit positions.
package system_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;

  localparam int unsigned STAT_DONE_BIT  = 0;
  localparam int unsigned STAT_STATE_LSB = 1;
  localparam int unsigned STAT_PLL_BIT   = 4;
  localparam int unsigned STAT_SW_BIT    = 5;
  localparam int unsigned STAT_POR_BIT   = 6;
  localparam int unsigned STAT_RST_LSB   = 8;

  localparam int unsigned CTRL_SW_REQ_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT    = 1;

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop level synchronizer; presets to 1 so the downstream logic sees "not ready" out of reset.
module reset_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/system_reset_sequencer.sv
// Holds per-domain resets while the PLL is unlocked or software asks, then releases them staggered.
module system_reset_sequencer
  import system_reset_pkg::*;
#(
  parameter int unsigned NUM_OUTS    = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_resetrequest,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                seq_done,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata
);

  localparam int unsigned IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  seq_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              pll_sync;
  logic              sw_req;
  logic              trigger;
  logic              ctrl_wr;
  logic              clr_causes;
  logic              pll_seen;
  logic [1:0]        prime;
  logic              cause_pll;
  logic              cause_sw;
  logic              cause_por;
  logic [DATA_W-1:0] status;
  logic              unused_bits;

  reset_sync_2ff u_pll_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_resetrequest),
    .q     (pll_sync)
  );

  assign ctrl_wr    = write & chipselect & (address == ADDR_CONTROL);
  assign clr_causes = ctrl_wr & writedata[CTRL_CLR_BIT];
  assign trigger    = pll_sync | sw_req;
  // The synchronizer preset is not a real PLL sample, so it must not be logged as a PLL cause.
  assign pll_seen   = pll_sync & prime[1];
  assign unused_bits = ^{read, writedata[DATA_W-1:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_req <= 1'b0;
      prime  <= 2'b00;
    end else begin
      sw_req <= ctrl_wr & writedata[CTRL_SW_REQ_BIT];
      prime  <= {prime[0], 1'b1};
    end
  end

  // Sticky causes; a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_por <= 1'b1;
      cause_pll <= 1'b0;
      cause_sw  <= 1'b0;
    end else begin
      cause_por <= cause_por & ~clr_causes;
      cause_pll <= pll_seen | (cause_pll & ~clr_causes);
      cause_sw  <= sw_req | (cause_sw & ~clr_causes);
    end
  end

  // Sequencer: any trigger restarts the hold window from scratch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= IDX_W'(1);
      rst_out  <= '1;
      seq_done <= 1'b0;
    end else if (trigger) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= IDX_W'(1);
      rst_out  <= '1;
      seq_done <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt        <= '0;
            idx        <= IDX_W'(1);
            rst_out[0] <= 1'b0;
            if (NUM_OUTS == 1) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == CNT_W'(STAGE_GAP - 1)) begin
            cnt     <= '0;
            rst_out <= rst_out & ~(NUM_OUTS'(1) << idx);
            idx     <= idx + 1'b1;
            if (idx == IDX_W'(NUM_OUTS - 1)) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= cnt;
        end
        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

  always_comb begin
    status                            = '0;
    status[STAT_DONE_BIT]             = seq_done;
    status[STAT_STATE_LSB +: 2]       = state;
    status[STAT_PLL_BIT]              = cause_pll;
    status[STAT_SW_BIT]               = cause_sw;
    status[STAT_POR_BIT]              = cause_por;
    status[STAT_RST_LSB +: NUM_OUTS]  = rst_out;
    readdata = (address == ADDR_STATUS) ? status : '0;
  end

endmodule
